// File: rtl/gpr_wb_ctrl.sv
// GPR scoreboard, write-back arbiter (EXU vs LSU with starvation guard) and registered regfile write port.
// Optional macro WB_FWD_EN: sources become ready in the commit cycle and the fwd_rsN_en outputs exist.
module gpr_wb_ctrl #(
   parameter int XLEN       = 64,
   parameter int STARVE_MAX = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            iss_valid,
   input  logic            iss_wr,
   input  logic [4:0]      iss_rd,
   input  logic [4:0]      iss_rs1,
   input  logic [4:0]      iss_rs2,
   output logic            iss_stall,
   input  logic            exu_valid,
   output logic            exu_ready,
   input  logic [4:0]      exu_rd,
   input  logic [XLEN-1:0] exu_data,
   input  logic            lsu_valid,
   output logic            lsu_ready,
   input  logic [4:0]      lsu_rd,
   input  logic [XLEN-1:0] lsu_data,
   output logic            rf_wr_en,
   output logic [4:0]      rf_rd,
   output logic [XLEN-1:0] rf_data
`ifdef WB_FWD_EN
   ,
   output logic            fwd_rs1_en,
   output logic            fwd_rs2_en
`endif
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [31:1]     busy_q;
   logic [31:1]     busy_nxt;
   logic [31:0]     busy;
   logic [3:0]      starve_q;
   logic [3:0]      starve_nxt;
   logic            rs1_busy;
   logic            rs2_busy;
   logic            waw_busy;
   logic            dispatch;
   logic            exu_grant;
   logic            lsu_grant;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;

   // x0 is never busy, so the zero index reads a hard-wired 0
   assign busy = {busy_q, 1'b0};

   always_comb begin
      exu_grant = exu_valid && (!lsu_valid || (starve_q == STARVE_LIM));
      lsu_grant = lsu_valid && !exu_grant;
      exu_ready = exu_grant;
      lsu_ready = lsu_grant;
      wb_rd     = exu_grant ? exu_rd   : lsu_rd;
      wb_data   = exu_grant ? exu_data : lsu_data;
   end

`ifdef WB_FWD_EN
   always_comb begin
      rs1_busy   = busy[iss_rs1] && !(rf_wr_en && (rf_rd == iss_rs1));
      rs2_busy   = busy[iss_rs2] && !(rf_wr_en && (rf_rd == iss_rs2));
      fwd_rs1_en = rf_wr_en && (rf_rd == iss_rs1) && (iss_rs1 != 5'd0);
      fwd_rs2_en = rf_wr_en && (rf_rd == iss_rs2) && (iss_rs2 != 5'd0);
   end
`else
   always_comb begin
      rs1_busy = busy[iss_rs1];
      rs2_busy = busy[iss_rs2];
   end
`endif

   // The destination (WAW) check always uses the raw scoreboard, even with forwarding
   always_comb begin
      waw_busy  = iss_wr && busy[iss_rd];
      iss_stall = iss_valid && (rs1_busy || rs2_busy || waw_busy);
      dispatch  = iss_valid && !iss_stall;
   end

   // NOTE: start from a full default so no path leaves a variable unassigned (no latch).
   always_comb begin
      busy_nxt = busy_q;
      if (rf_wr_en && (rf_rd != 5'd0)) busy_nxt[rf_rd] = 1'b0;
      // Set after clear: a same-edge dispatch of the committing register keeps it busy
      if (dispatch && iss_wr && (iss_rd != 5'd0)) busy_nxt[iss_rd] = 1'b1;
   end

   always_comb begin
      starve_nxt = starve_q;
      if (exu_grant) begin
         starve_nxt = 4'd0;
      end else if (exu_valid && (starve_q != STARVE_LIM)) begin
         starve_nxt = starve_q + 4'd1;
      end
   end

   // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q   <= '0;
         starve_q <= '0;
         rf_wr_en <= 1'b0;
         rf_rd    <= '0;
         rf_data  <= '0;
      end else begin
         busy_q   <= busy_nxt;
         starve_q <= starve_nxt;
         rf_wr_en <= (exu_grant || lsu_grant) && (wb_rd != 5'd0);
         if (exu_grant || lsu_grant) begin
            rf_rd   <= wb_rd;
            rf_data <= wb_data;
         end
      end
   end

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Self-checking bench for gpr_wb_ctrl: table-driven arbitration/write-back vectors with a
// queue of expected regfile writes, plus hand sequences for hazards, set-vs-clear and async reset.
module tb_gpr_wb_ctrl;

   localparam int XLEN = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic            iss_valid, iss_wr;
   logic [4:0]      iss_rd, iss_rs1, iss_rs2;
   logic            iss_stall;
   logic            exu_valid, exu_ready;
   logic [4:0]      exu_rd;
   logic [XLEN-1:0] exu_data;
   logic            lsu_valid, lsu_ready;
   logic [4:0]      lsu_rd;
   logic [XLEN-1:0] lsu_data;
   logic            rf_wr_en;
   logic [4:0]      rf_rd;
   logic [XLEN-1:0] rf_data;
`ifdef WB_FWD_EN
   logic            fwd_rs1_en, fwd_rs2_en;
`endif

   gpr_wb_ctrl #(.XLEN(XLEN), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_rd(iss_rd),
      .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_stall(iss_stall),
      .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .rf_wr_en(rf_wr_en), .rf_rd(rf_rd), .rf_data(rf_data)
`ifdef WB_FWD_EN
      , .fwd_rs1_en(fwd_rs1_en), .fwd_rs2_en(fwd_rs2_en)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            ev;
      logic [4:0]      erd;
      logic [XLEN-1:0] ed;
      logic            lv;
      logic [4:0]      lrd;
      logic [XLEN-1:0] ld;
      logic            xr;
      logic            lr;
   } vec_t;

   typedef struct {
      logic            en;
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } wb_t;

   vec_t vecs[15];
   wb_t  sb_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      iss_valid = 0; iss_wr = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
      exu_valid = 0; exu_rd = 0; exu_data = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      wb_t exp_wb;
      wb_t got;
      logic [4:0]      last_rd   = '0;
      logic [XLEN-1:0] last_data = '0;

      vecs[0] = '{1'b1, 5'd1, 64'h11, 1'b0, 5'd0, 64'h0, 1'b1, 1'b0};
      vecs[1] = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd2, 64'h22, 1'b0, 1'b1};
      vecs[2] = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd0, 64'hDEAD, 1'b0, 1'b1};
      vecs[3] = '{1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 5'd6, 64'h66, 1'b0, 5'd0, 64'h0, 1'b1, 1'b0};
      // Both requesters held: four LSU grants then one EXU grant, repeating
      for (int i = 0; i < 10; i++)
         vecs[5+i] = '{1'b1, 5'(8 + i), 64'h100 + 64'(i), 1'b1, 5'(20 + i), 64'h200 + 64'(i),
                       (i % 5) == 4, (i % 5) != 4};

      idle();
      rst = 1'b1;
      #1;
      check("reset rf_wr_en", 64'(rf_wr_en), 64'd0);
      check("reset rf_rd", 64'(rf_rd), 64'd0);
      check("reset rf_data", rf_data, 64'd0);
      #12 rst = 1'b0;
      tick();

      for (int v = 0; v < 15; v++) begin
         exu_valid = vecs[v].ev; exu_rd = vecs[v].erd; exu_data = vecs[v].ed;
         lsu_valid = vecs[v].lv; lsu_rd = vecs[v].lrd; lsu_data = vecs[v].ld;
         #1;
         check($sformatf("vec%0d exu_ready", v), 64'(exu_ready), 64'(vecs[v].xr));
         check($sformatf("vec%0d lsu_ready", v), 64'(lsu_ready), 64'(vecs[v].lr));
         if (vecs[v].xr) begin
            last_rd = vecs[v].erd; last_data = vecs[v].ed;
            exp_wb = '{vecs[v].erd != 5'd0, last_rd, last_data};
         end else if (vecs[v].lr) begin
            last_rd = vecs[v].lrd; last_data = vecs[v].ld;
            exp_wb = '{vecs[v].lrd != 5'd0, last_rd, last_data};
         end else begin
            exp_wb = '{1'b0, last_rd, last_data};
         end
         sb_q.push_back(exp_wb);
         tick();
         got = sb_q.pop_front();
         check($sformatf("vec%0d rf_wr_en", v), 64'(rf_wr_en), 64'(got.en));
         check($sformatf("vec%0d rf_rd", v), 64'(rf_rd), 64'(got.rd));
         check($sformatf("vec%0d rf_data", v), rf_data, got.data);
      end

      // RAW hazard on x5 resolved by an LSU write-back
      idle();
      tick();
      iss_valid = 1; iss_wr = 1; iss_rd = 5;
      #1 check("raw dispatch stall", 64'(iss_stall), 64'd0);
      tick();
      iss_wr = 0; iss_rd = 0; iss_rs1 = 5;
      #1 check("raw rs1 stall a", 64'(iss_stall), 64'd1);
      tick();
      check("raw rs1 stall b", 64'(iss_stall), 64'd1);
      lsu_valid = 1; lsu_rd = 5; lsu_data = 64'h55;
      #1;
      check("raw lsu_ready", 64'(lsu_ready), 64'd1);
      check("raw stall at grant", 64'(iss_stall), 64'd1);
      tick();
      lsu_valid = 0;
      #1;
      check("raw commit en", 64'(rf_wr_en), 64'd1);
      check("raw commit rd", 64'(rf_rd), 64'd5);
`ifdef WB_FWD_EN
      check("raw stall commit cycle", 64'(iss_stall), 64'd0);
      check("raw fwd_rs1_en", 64'(fwd_rs1_en), 64'd1);
      check("raw fwd_rs2_en", 64'(fwd_rs2_en), 64'd0);
`else
      check("raw stall commit cycle", 64'(iss_stall), 64'd1);
`endif
      tick();
      check("raw stall after commit", 64'(iss_stall), 64'd0);
      idle();

      // Dispatch of x7 on the edge where x7 commits: set wins
      lsu_valid = 1; lsu_rd = 7; lsu_data = 64'h77;
      #1 check("sw lsu_ready", 64'(lsu_ready), 64'd1);
      tick();
      lsu_valid = 0;
      iss_valid = 1; iss_wr = 1; iss_rd = 7;
      #1;
      check("sw commit en", 64'(rf_wr_en), 64'd1);
      check("sw commit rd", 64'(rf_rd), 64'd7);
      check("sw dispatch stall", 64'(iss_stall), 64'd0);
      tick();
      iss_wr = 0; iss_rd = 0; iss_rs2 = 7;
      #1 check("sw rs2 stall a", 64'(iss_stall), 64'd1);
      tick();
      check("sw rs2 stall b", 64'(iss_stall), 64'd1);
      idle();

      // Build up starvation, mark x3 busy with a commit pending, then pulse reset mid-cycle
      exu_valid = 1; lsu_valid = 1; exu_rd = 12; lsu_rd = 13;
      tick();
      lsu_rd = 9; lsu_data = 64'h99;
      iss_valid = 1; iss_wr = 1; iss_rd = 3;
      #1 check("rst pre dispatch stall", 64'(iss_stall), 64'd0);
      tick();
      exu_valid = 0; lsu_valid = 0;
      iss_wr = 0; iss_rd = 0; iss_rs1 = 3;
      #1;
      check("rst pre rs1 stall", 64'(iss_stall), 64'd1);
      check("rst pre rf_wr_en", 64'(rf_wr_en), 64'd1);
      rst = 1'b1;
      #1;
      check("rst async rf_wr_en", 64'(rf_wr_en), 64'd0);
      check("rst async rf_rd", 64'(rf_rd), 64'd0);
      check("rst async rf_data", rf_data, 64'd0);
      check("rst rs1 stall", 64'(iss_stall), 64'd0);
      iss_valid = 0;
      exu_valid = 1; lsu_valid = 1;
      #1;
      check("rst exu_ready", 64'(exu_ready), 64'd0);
      check("rst lsu_ready", 64'(lsu_ready), 64'd1);
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         check($sformatf("post-rst k%0d exu_ready", k), 64'(exu_ready), 64'((k % 5) == 4));
         check($sformatf("post-rst k%0d lsu_ready", k), 64'(lsu_ready), 64'((k % 5) != 4));
         tick();
      end
      idle();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
